// File: rtl/defines.sv
// rtl/defines.sv - shared constants and types for the io_uart_tx core
package defines;

    // io_cs fan-out: this core owns bit IO_UART_TX_CORE of the LSU chip-select vector
    localparam int NUM_IO_CORES    = 4;
    localparam int IO_UART_TX_CORE = 1;

    // Register byte offsets within the core's 0x100 window
    localparam logic [7:0] UART_TXDATA_OFFSET = 8'h00;
    localparam logic [7:0] UART_STATUS_OFFSET = 8'h04;
    localparam logic [7:0] UART_BAUD_OFFSET   = 8'h08;

    // STATUS bit positions
    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_COUNT_MSB = 11;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO still lands when a pop frees the head slot in the same cycle
    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - MMIO UART transmitter: register file, TX FIFO and 8N1 serializer
module io_uart_tx
    import defines::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int RESET_BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_cs,
    input  logic        io_rd_en,
    input  logic        io_wr_en,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_wr_data,
    input  logic [3:0]  io_wr_strobe,
    output logic [31:0] io_rd_data,
    output logic        io_rd_valid,
    output logic        uart_tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd;
    logic          wr;
    logic          mapped;
    logic [1:0]    reg_sel;
    logic          sel_txdata;
    logic          sel_status;
    logic          sel_baud;
    logic          push_req;
    logic          ovf_set;
    logic          ovf_clr;

    logic          fifo_pop;
    logic [7:0]    fifo_pop_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [15:0]   baud_q, baud_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   status_word;

    uart_tx_state_e state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   div_q, div_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, tx_d;
    logic [15:0]   frame_div;
    logic          bit_done;
    logic          frame_start;

    // Address bits below word granularity and upper byte lanes carry nothing for this core
    logic unused_inputs;
    assign unused_inputs = ^{io_addr[1:0], io_wr_data[31:16], io_wr_strobe[3:2]};

    assign rd         = io_cs & io_rd_en;
    assign wr         = io_cs & io_wr_en;
    assign mapped     = (io_addr[7:4] == 4'h0);
    assign reg_sel    = io_addr[3:2];
    assign sel_txdata = mapped && (reg_sel == UART_TXDATA_OFFSET[3:2]);
    assign sel_status = mapped && (reg_sel == UART_STATUS_OFFSET[3:2]);
    assign sel_baud   = mapped && (reg_sel == UART_BAUD_OFFSET[3:2]);
    assign push_req   = wr && sel_txdata && io_wr_strobe[0];
    assign ovf_clr    = wr && sel_status && io_wr_strobe[0] && io_wr_data[STATUS_OVF_BIT];
    assign ovf_set    = push_req && fifo_full && !fifo_pop;

    assign uart_tx     = tx_q;
    assign io_rd_data  = rd_data_q;
    assign io_rd_valid = rd_valid_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_req),
        .push_data (io_wr_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // STATUS word assembly
    always_comb begin
        status_word                                    = '0;
        status_word[STATUS_FULL_BIT]                   = fifo_full;
        status_word[STATUS_EMPTY_BIT]                  = fifo_empty;
        status_word[STATUS_BUSY_BIT]                   = (state_q != UART_IDLE);
        status_word[STATUS_OVF_BIT]                    = ovf_q;
        status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 4'(fifo_count);
    end

    // Register writes and the registered read response; a set of overflow beats a clear
    always_comb begin
        baud_d = baud_q;
        if (wr && sel_baud) begin
            if (io_wr_strobe[0]) baud_d[7:0]  = io_wr_data[7:0];
            if (io_wr_strobe[1]) baud_d[15:8] = io_wr_data[15:8];
        end
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        rd_valid_d = rd;
        rd_data_d  = '0;
        if (rd) begin
            if (sel_status)    rd_data_d = status_word;
            else if (sel_baud) rd_data_d = {16'h0000, baud_q};
        end
    end

    // Register file state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_q     <= 16'(RESET_BAUD_DIV);
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            baud_q     <= baud_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Serializer next state; a new frame may start from IDLE or straight out of a finished STOP
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        frame_div   = (baud_q == 16'd0) ? 16'd1 : baud_q;
        bit_done    = (cnt_q == 16'd0);
        frame_start = !fifo_empty &&
                      ((state_q == UART_IDLE) || ((state_q == UART_STOP) && bit_done));

        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
            end
            UART_START: begin
                if (bit_done) begin
                    state_d   = UART_DATA;
                    cnt_d     = div_q - 16'd1;
                    bit_idx_d = 3'd0;
                    tx_d      = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            UART_DATA: begin
                if (bit_done) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    state_d = UART_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = UART_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (frame_start) begin
            fifo_pop = 1'b1;
            state_d  = UART_START;
            div_d    = frame_div;
            cnt_d    = frame_div - 16'd1;
            shreg_d  = fifo_pop_data;
            tx_d     = 1'b0;
        end
    end

    // Serializer state; reset drives the line idle immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= UART_IDLE;
            cnt_q     <= '0;
            div_q     <= 16'd1;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - self-checking bench for io_uart_tx
module tb_io_uart_tx;

    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_cs;
    logic        io_rd_en;
    logic        io_wr_en;
    logic [7:0]  io_addr;
    logic [31:0] io_wr_data;
    logic [3:0]  io_wr_strobe;
    logic [31:0] io_rd_data;
    logic        io_rd_valid;
    logic        uart_tx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
    } exp_frame_t;

    exp_frame_t exp_q[$];
    int         start_log[$];
    int         last_end_cyc = 0;
    bit         mon_en = 1'b0;
    bit         mon_busy = 1'b0;

    io_uart_tx #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .RESET_BAUD_DIV (868)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .io_cs        (io_cs),
        .io_rd_en     (io_rd_en),
        .io_wr_en     (io_wr_en),
        .io_addr      (io_addr),
        .io_wr_data   (io_wr_data),
        .io_wr_strobe (io_wr_strobe),
        .io_rd_data   (io_rd_data),
        .io_rd_valid  (io_rd_valid),
        .uart_tx      (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int count, input bit busy, input bit ovf);
        logic [31:0] w;
        w = 32'(count) << 8;
        if (count == FIFO_DEPTH) w = w | 32'h1;
        if (count == 0)          w = w | 32'h2;
        if (busy)                w = w | 32'h4;
        if (ovf)                 w = w | 32'h8;
        return w;
    endfunction

    task automatic bus_idle();
        io_cs = 1'b0; io_rd_en = 1'b0; io_wr_en = 1'b0;
        io_addr = 8'h00; io_wr_data = 32'h0; io_wr_strobe = 4'h0;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        io_cs = 1'b1; io_wr_en = 1'b1; io_addr = a; io_wr_data = d; io_wr_strobe = s;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        io_cs = 1'b1; io_rd_en = 1'b1; io_addr = a;
        @(negedge clk);
        bus_idle();
        check({tag, "_valid"}, 32'(io_rd_valid), 32'h1);
        check(tag, io_rd_data, exp);
    endtask

    task automatic push_burst(input logic [7:0] bytes [16], input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            io_cs = 1'b1; io_wr_en = 1'b1; io_addr = 8'h00;
            io_wr_data = {24'h0, bytes[i]}; io_wr_strobe = 4'h1;
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic expect_frame(input logic [7:0] data, input int div, input bit b2b);
        exp_frame_t e;
        e.data = data; e.div = div; e.b2b = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_drained"}, 32'(done), 32'h1);
        read_check({tag, "_status_idle"}, 8'h04, exp_status(0, 1'b0, 1'b0));
    endtask

    // Line monitor: each frame is div cycles low, 8 data bits LSB first, div cycles high
    initial begin : line_monitor
        int gap;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst) begin
                gap = 1000;
            end else if (uart_tx) begin
                gap++;
            end else begin
                mon_busy = 1'b1;
                start_log.push_back(cyc);
                check("frame_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    exp_frame_t e;
                    int         mism;
                    logic [7:0] got;
                    e = exp_q.pop_front();
                    if (e.b2b) check("frame_gap", 32'(gap), 32'h0);
                    mism = 0;
                    got  = 8'h00;
                    for (int k = 1; k < 10 * e.div; k++) begin
                        int   bitn;
                        logic lvl;
                        @(negedge clk);
                        bitn = k / e.div;
                        if (bitn == 0)      lvl = 1'b0;
                        else if (bitn == 9) lvl = 1'b1;
                        else                lvl = e.data[bitn-1];
                        if (uart_tx !== lvl) mism++;
                        if (bitn >= 1 && bitn <= 8 && (k % e.div) == 0) got[bitn-1] = uart_tx;
                    end
                    check("frame_shape", 32'(mism), 32'h0);
                    check("frame_byte", {24'h0, got}, {24'h0, e.data});
                    last_end_cyc = cyc;
                end
                gap = 0;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0] bytes [16];
        int         s0;
        int         t_a;
        int         busy_n;
        bit         seen;

        bus_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(uart_tx), 32'h1);
        check("reset_rd_valid", 32'(io_rd_valid), 32'h0);
        check("reset_rd_data", io_rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Read with chip select low gets no response
        @(negedge clk);
        io_cs = 1'b0; io_rd_en = 1'b1; io_addr = 8'h04;
        @(negedge clk);
        check("cs0_rd_valid", 32'(io_rd_valid), 32'h0);
        check("cs0_rd_data", io_rd_data, 32'h0);
        bus_idle();

        read_check("baud_reset", 8'h08, 32'h0000_0364);
        read_check("status_reset", 8'h04, exp_status(0, 1'b0, 1'b0));
        read_check("txdata_read", 8'h00, 32'h0);
        read_check("reserved_read", 8'h0C, 32'h0);
        read_check("unmapped_read", 8'h14, 32'h0);
        reg_write(8'h18, 32'h0000_0005, 4'hF);
        read_check("unmapped_write_ignored", 8'h08, 32'h0000_0364);
        reg_write(8'h08, 32'hFFFF_0005, 4'hF);
        read_check("baud_upper_zero", 8'h08, 32'h0000_0005);
        reg_write(8'h08, 32'h0000_0300, 4'h2);
        read_check("baud_lane1", 8'h08, 32'h0000_0305);

        // 0x55 at div 4, counting busy cycles through back-to-back STATUS reads
        reg_write(8'h08, 32'd4, 4'h3);
        expect_frame(8'h55, 4, 1'b0);
        reg_write(8'h00, 32'h55, 4'h1);
        busy_n = 0;
        seen = 1'b0;
        io_cs = 1'b1; io_rd_en = 1'b1; io_addr = 8'h04;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (io_rd_valid && io_rd_data[2]) begin
                busy_n++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        bus_idle();
        check("busy_cycles", 32'(busy_n), 32'd40);
        wait_idle("div4", 200);

        // Three consecutive pushes at div 2 run as one 60-cycle burst of frames
        reg_write(8'h08, 32'd2, 4'h3);
        bytes[0] = 8'hA3; bytes[1] = 8'h3C; bytes[2] = 8'hF0;
        for (int i = 0; i < 3; i++) expect_frame(bytes[i], 2, i > 0);
        s0 = start_log.size();
        push_burst(bytes, 3);
        wait_idle("b2b", 300);
        check("b2b_total_cycles", 32'(last_end_cyc - start_log[s0] + 1), 32'd60);

        // BAUD_DIV of zero behaves as one cycle per bit
        reg_write(8'h08, 32'd0, 4'h3);
        expect_frame(8'h96, 1, 1'b0);
        s0 = start_log.size();
        bytes[0] = 8'h96;
        push_burst(bytes, 1);
        wait_idle("div0", 100);
        check("div0_frame_cycles", 32'(last_end_cyc - start_log[s0] + 1), 32'd10);

        // Randomized bursts at random divisors
        for (int it = 0; it < 3; it++) begin
            int d;
            int n;
            d = $urandom_range(0, 5);
            n = $urandom_range(1, 8);
            reg_write(8'h08, 32'(d), 4'h3);
            for (int i = 0; i < n; i++) begin
                bytes[i] = 8'($urandom);
                expect_frame(bytes[i], (d == 0) ? 1 : d, i > 0);
            end
            push_burst(bytes, n);
            wait_idle("random", 600);
        end

        // Overflow while stalled, push coinciding with pop, and mid-frame divisor change
        reg_write(8'h08, 32'd100, 4'h3);
        expect_frame(8'h11, 100, 1'b0);
        s0 = start_log.size();
        bytes[0] = 8'h11;
        push_burst(bytes, 1);
        for (int i = 0; i < 50 && start_log.size() == s0; i++) @(negedge clk);
        check("ovf_first_frame_started", 32'(start_log.size() > s0), 32'h1);
        t_a = (start_log.size() > s0) ? start_log[s0] : cyc;
        for (int i = 0; i < 8; i++) begin
            bytes[i] = 8'($urandom);
            expect_frame(bytes[i], (i == 0) ? 100 : 1, 1'b1);
        end
        push_burst(bytes, 8);
        read_check("status_full", 8'h04, exp_status(8, 1'b1, 1'b0));
        bytes[0] = 8'h99;
        push_burst(bytes, 1);
        read_check("status_overflow", 8'h04, exp_status(8, 1'b1, 1'b1));
        reg_write(8'h04, 32'h0000_0008, 4'h1);
        read_check("status_ovf_cleared", 8'h04, exp_status(8, 1'b1, 1'b0));
        while (cyc < t_a + 998) @(negedge clk);
        bytes[0] = 8'hC7;
        expect_frame(8'hC7, 1, 1'b1);
        push_burst(bytes, 1);
        read_check("status_push_with_pop", 8'h04, exp_status(8, 1'b1, 1'b0));
        reg_write(8'h08, 32'd1, 4'h3);
        wait_idle("ovf", 2500);

        // Reset in the middle of DATA
        mon_en = 1'b0;
        reg_write(8'h08, 32'd4, 4'h3);
        bytes[0] = 8'h00; bytes[1] = 8'hA5;
        push_burst(bytes, 2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!uart_tx) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_frame_started", 32'(seen), 32'h1);
        repeat (10) @(negedge clk);
        check("rst_pre_tx_low", 32'(uart_tx), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_tx", 32'(uart_tx), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        read_check("rst_status", 8'h04, exp_status(0, 1'b0, 1'b0));
        read_check("rst_baud", 8'h08, 32'h0000_0364);
        check("rst_tx_idle", 32'(uart_tx), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter RESET_BAUD_DIV, default 868: BAUD_DIV reset value, in clk cycles per bit.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port io_cs, input, 1 bit: chip select for this core, one bit of the LSU io_cs vector.
REQ-006 SHALL have port io_rd_en, input, 1 bit: MMIO read strobe from LSU.
REQ-007 SHALL have port io_wr_en, input, 1 bit: MMIO write strobe from LSU.
REQ-008 SHALL have port io_addr, input, 8 bits: byte offset within the core's 0x100 window.
REQ-009 SHALL have port io_wr_data, input, 32 bits: lane-aligned write data.
REQ-010 SHALL have port io_wr_strobe, input, 4 bits: byte enables.
REQ-011 SHALL have port io_rd_data, output, 32 bits: read response data.
REQ-012 SHALL have port io_rd_valid, output, 1 bit: read response qualifier.
REQ-013 SHALL have port uart_tx, output, 1 bit: serial line, idle high.

Function
REQ-014 SHALL decode an access as rd = io_cs & io_rd_en and wr = io_cs & io_wr_en; register select is io_addr[3:2]; io_addr[7:4] != 0 is unmapped.
REQ-015 SHALL implement register TXDATA at offset 0x00: a write with io_wr_strobe[0] pushes io_wr_data[7:0] into the FIFO; a read returns 0.
REQ-016 SHALL implement register STATUS at offset 0x04, read-only except bit3:
- bit0 full
- bit1 empty
- bit2 busy (serializer not IDLE)
- bit3 overflow (sticky; cleared by a write with bit3=1 and strobe[0])
- bits[11:8] FIFO count
- all other bits 0
REQ-017 SHALL implement register BAUD_DIV at offset 0x08: bits[15:0] read/write, written per byte lane via strobe[1:0]; bits[31:16] read 0.
REQ-018 SHALL return io_rd_data registered: io_rd_valid=1 exactly one cycle after rd, else 0; io_rd_data=0 when io_rd_valid=0.
REQ-019 SHALL return 0 for reads to unmapped or reserved offsets and ignore writes to them.
REQ-020 SHALL accept a push when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle; otherwise drop the byte and set overflow.
REQ-021 SHALL let overflow set win over overflow clear when both occur in the same cycle.
REQ-022 SHALL implement the serializer FSM, 8N1, LSB first:
- IDLE -> START when FIFO non-empty; pop and latch the byte in that same cycle; latch div = max(BAUD_DIV,1).
- START (uart_tx=0) -> DATA after div cycles.
- DATA: shift 8 bits, div cycles each -> STOP.
- STOP (uart_tx=1) for div cycles -> IDLE.
REQ-023 SHALL use a baud counter that loads div-1 at every bit start and counts down; the bit ends when the counter is 0.
REQ-024 SHALL make a BAUD_DIV change mid-frame take effect only at the next frame start.
REQ-025 SHALL produce back-to-back frames with no idle gap when the FIFO is non-empty at STOP end (STOP -> START directly with a pop).
REQ-026 SHALL make a frame last exactly 10*div cycles.

Reset
REQ-027 SHALL, on rst low, asynchronously clear: FIFO empty, pointers 0, overflow 0, FSM IDLE, uart_tx=1, io_rd_valid=0, io_rd_data=0, BAUD_DIV=RESET_BAUD_DIV.
REQ-028 SHALL abort any frame in progress on reset, return uart_tx high immediately, and discard FIFO contents.

Structure
REQ-029 SHALL place register offsets (UART_TXDATA_OFFSET, UART_STATUS_OFFSET, UART_BAUD_OFFSET), the FSM state enum uart_tx_state_e, and the STATUS bit positions in package defines.
REQ-030 SHALL take the core index within the io_cs vector from the defines constants alongside NUM_IO_CORES.
REQ-031 SHALL use one sub-module, sync_fifo (parameterised WIDTH=8, DEPTH; push, pop, full, empty, count); FSM, counter and register file stay in io_uart_tx.

Verification
REQ-032 SHALL cover: BAUD_DIV=4, write 0x55 to TXDATA -> uart_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles; busy=1 for 40 cycles.
REQ-033 SHALL cover: 9 pushes with FIFO_DEPTH=8 while the serializer is stalled mid-frame -> the 9th is accepted only if it coincides with a pop, else overflow=1; STATUS read returns count in bits[11:8].
REQ-034 SHALL cover: 3 bytes written in consecutive cycles with BAUD_DIV=2 -> 3 frames, 60 cycles total, no idle between STOP and START.
REQ-035 SHALL cover: read STATUS with io_cs=0 -> io_rd_valid stays 0; read 0x08 after reset -> io_rd_valid next cycle, data 0x00000364.
REQ-036 SHALL cover: BAUD_DIV=0 written, byte sent -> each bit lasts 1 cycle (10-cycle frame).
REQ-037 SHALL cover: rst asserted mid-DATA -> uart_tx=1 without waiting for clk; after release, empty=1 and busy=0.
